// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbol decoder.
// Contents: decoder FSM state encoding and the sentinel-code width helper.
package morse_pkg;

   // IDLE: key up, no open letter; PRESS: key down; GAP: key up, open letter.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // A letter of up to max_symbols symbols plus its one-bit sentinel marker.
   function automatic int unsigned code_width(input int unsigned max_symbols);
      return max_symbols + 1;
   endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Free-running prescaler producing a one-cycle timing tick every TICK_DIV clocks.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   tick_o  - registered one-cycle pulse, once per TICK_DIV cycles
module morse_tick_gen #(
   parameter int unsigned TICK_DIV = 1_250_000
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick_o
);

   localparam int unsigned DIV_W = $clog2(TICK_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;

   // Wrap the divider and flag the wrap cycle.
   always_comb begin
      div_d  = div_q + DIV_W'(1);
      tick_d = 1'b0;
      if (div_q == DIV_W'(TICK_DIV - 1)) begin
         div_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/morse_symbol_decoder.sv
// Decodes a raw Morse key into sentinel-encoded letters.
// Presses are timed in prescaler ticks and classified as dot/dash; a long
// key-up closes the letter, which is offered on a valid/ready output.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   key_in           - raw key (asynchronous), high = pressed
//   clear            - synchronous clear of buffer, output and flags
//   out_ready        - consumer accepts code_out this cycle
//   code_out         - letter: symbols in low bits, 1 above the last symbol
//   code_valid       - code_out holds an unconsumed letter
//   sym_count        - symbols buffered in the open letter
//   sym_reg          - buffered symbols, bit i = symbol i (0 dot, 1 dash)
//   overflow, drop   - sticky: symbol lost to full buffer / letter lost to backpressure
module morse_symbol_decoder
   import morse_pkg::*;
#(
   parameter int unsigned TICK_DIV         = 1_250_000,
   parameter int unsigned DOT_MAX_TICKS    = 2,
   parameter int unsigned LETTER_GAP_TICKS = 6,
   parameter int unsigned MAX_SYMBOLS      = 5
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               key_in,
   input  logic                               clear,
   input  logic                               out_ready,
   output logic [code_width(MAX_SYMBOLS)-1:0] code_out,
   output logic                               code_valid,
   output logic [$clog2(MAX_SYMBOLS+1)-1:0]   sym_count,
   output logic [MAX_SYMBOLS-1:0]             sym_reg,
   output logic                               overflow,
   output logic                               drop
);

   localparam int unsigned CODE_W  = code_width(MAX_SYMBOLS);
   localparam int unsigned CNT_W   = $clog2(MAX_SYMBOLS + 1);
   localparam int unsigned PRESS_W = $clog2(DOT_MAX_TICKS + 2);
   localparam int unsigned GAP_W   = $clog2(LETTER_GAP_TICKS + 1);

   logic tick;

   morse_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .tick_o  (tick)
   );

   // Two-flop synchronizer; arm_q marks when key_s_q reflects the real key after reset.
   logic       sync1_q, key_s_q;
   logic [1:0] arm_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         key_s_q <= 1'b0;
         arm_q   <= 2'b00;
      end else begin
         sync1_q <= key_in;
         key_s_q <= sync1_q;
         arm_q   <= {arm_q[0], 1'b1};
      end
   end

   state_e              state_q, state_d;
   logic [PRESS_W-1:0]  press_q, press_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [MAX_SYMBOLS-1:0] sym_reg_q, sym_reg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                drop_q, drop_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                valid_q, valid_d;
   logic                wait_q, wait_d;
   logic [CODE_W-1:0]   new_code;
   logic                complete;
   logic                press_ok;
   logic                is_dash;

   // Sentinel-encoded form of the open letter.
   always_comb begin
      new_code = '0;
      for (int unsigned i = 0; i < MAX_SYMBOLS; i++) begin
         if (CNT_W'(i) < cnt_q) new_code[i] = sym_reg_q[i];
      end
      for (int unsigned i = 0; i <= MAX_SYMBOLS; i++) begin
         if (CNT_W'(i) == cnt_q) new_code[i] = 1'b1;
      end
   end

   // wait_q blocks a key that was already down at reset or clear until it is released.
   assign press_ok = key_s_q & ~wait_q;
   assign is_dash  = (press_q > PRESS_W'(DOT_MAX_TICKS));

   // Next-state, buffer and output handshake logic.
   always_comb begin
      state_d   = state_q;
      press_d   = press_q;
      gap_d     = gap_q;
      sym_reg_d = sym_reg_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      code_d    = code_q;
      valid_d   = valid_q;
      wait_d    = wait_q;
      complete  = 1'b0;

      if (arm_q[1] && !key_s_q) wait_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (press_ok) begin
               state_d = ST_PRESS;
               press_d = '0;
               gap_d   = '0;
            end
         end
         ST_PRESS: begin
            if (!key_s_q) begin
               gap_d = '0;
               if (press_q == '0) begin
                  // Sub-tick press is noise: resume where we were.
                  state_d = (cnt_q == '0) ? ST_IDLE : ST_GAP;
               end else begin
                  state_d = ST_GAP;
                  if (cnt_q == CNT_W'(MAX_SYMBOLS)) begin
                     ovf_d = 1'b1;
                  end else begin
                     for (int unsigned i = 0; i < MAX_SYMBOLS; i++) begin
                        if (CNT_W'(i) == cnt_q) sym_reg_d[i] = is_dash;
                     end
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end else if (tick && (press_q != PRESS_W'(DOT_MAX_TICKS + 1))) begin
               press_d = press_q + PRESS_W'(1);
            end
         end
         ST_GAP: begin
            if (press_ok) begin
               state_d = ST_PRESS;
               press_d = '0;
               gap_d   = '0;
            end else if (tick) begin
               if (gap_q == GAP_W'(LETTER_GAP_TICKS - 1)) begin
                  complete  = 1'b1;
                  state_d   = ST_IDLE;
                  gap_d     = '0;
                  sym_reg_d = '0;
                  cnt_d     = '0;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (complete) begin
         if (!valid_q || out_ready) begin
            code_d  = new_code;
            valid_d = 1'b1;
         end else begin
            drop_d = 1'b1;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      if (clear) begin
         state_d   = ST_IDLE;
         press_d   = '0;
         gap_d     = '0;
         sym_reg_d = '0;
         cnt_d     = '0;
         ovf_d     = 1'b0;
         drop_d    = 1'b0;
         code_d    = '0;
         valid_d   = 1'b0;
         wait_d    = key_s_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         press_q   <= '0;
         gap_q     <= '0;
         sym_reg_q <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         drop_q    <= 1'b0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         wait_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         press_q   <= press_d;
         gap_q     <= gap_d;
         sym_reg_q <= sym_reg_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         drop_q    <= drop_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         wait_q    <= wait_d;
      end
   end

   assign code_out   = code_q;
   assign code_valid = valid_q;
   assign sym_count  = cnt_q;
   assign sym_reg    = sym_reg_q;
   assign overflow   = ovf_q;
   assign drop       = drop_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Self-checking bench for morse_symbol_decoder (TICK_DIV=4, dot <= 2 ticks,
// letter gap 6 ticks, 5 symbols per letter).
`timescale 1ns/1ps
module tb_morse_symbol_decoder;

   localparam int unsigned TICK_DIV         = 4;
   localparam int unsigned DOT_MAX_TICKS    = 2;
   localparam int unsigned LETTER_GAP_TICKS = 6;
   localparam int unsigned MAX_SYMBOLS      = 5;
   localparam int unsigned CW               = MAX_SYMBOLS + 1;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   key_in = 1'b0;
   logic                   clear = 1'b0;
   logic                   out_ready = 1'b0;
   logic [CW-1:0]          code_out;
   logic                   code_valid;
   logic [2:0]             sym_count;
   logic [MAX_SYMBOLS-1:0] sym_reg;
   logic                   overflow;
   logic                   drop;

   int checks = 0;
   int failures = 0;
   int valid_cnt = 0;
   logic [CW-1:0] got_q[$];
   logic [CW-1:0] exp_q[$];

   always #5 clk = ~clk;

   morse_symbol_decoder #(
      .TICK_DIV         (TICK_DIV),
      .DOT_MAX_TICKS    (DOT_MAX_TICKS),
      .LETTER_GAP_TICKS (LETTER_GAP_TICKS),
      .MAX_SYMBOLS      (MAX_SYMBOLS)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_in     (key_in),
      .clear      (clear),
      .out_ready  (out_ready),
      .code_out   (code_out),
      .code_valid (code_valid),
      .sym_count  (sym_count),
      .sym_reg    (sym_reg),
      .overflow   (overflow),
      .drop       (drop)
   );

   // Record valid cycles and every accepted letter.
   always @(negedge clk) begin
      if (reset_n) begin
         if (code_valid) valid_cnt++;
         if (code_valid && out_ready) got_q.push_back(code_out);
      end
   end

   // Reference: first min(n, MAX) symbols in the low bits, a 1 just above them.
   function automatic logic [CW-1:0] letter_code(input int n, input logic [7:0] syms);
      int k;
      int v;
      k = (n > int'(MAX_SYMBOLS)) ? int'(MAX_SYMBOLS) : n;
      v = (1 << k) | (int'(syms) & ((1 << k) - 1));
      return CW'(v);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the key for len cycles. 5..7 cycles is 1..2 ticks (dot), 14..20 is >=3 (dash).
   task automatic press(input int len);
      key_in = 1'b1;
      step(len);
      key_in = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic send_symbols(input int n, input logic [7:0] syms, input bit glitches);
      for (int i = 0; i < n; i++) begin
         press(syms[i] ? int'($urandom_range(14, 20)) : int'($urandom_range(5, 7)));
         if (i != n - 1) begin
            step(int'($urandom_range(4, 8)));
            if (glitches && ($urandom_range(0, 3) == 0)) begin
               press(1);
               step(3);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      out_ready = 1'b1;
      step(3);
      checks++; if (code_out !== '0) begin failures++; $display("FAIL reset_code_out: got %b expected %b", code_out, 6'b0); end
      checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL reset_code_valid: got %b expected 0", code_valid); end
      checks++; if (sym_count !== 3'd0) begin failures++; $display("FAIL reset_sym_count: got %0d expected 0", sym_count); end
      checks++; if (sym_reg !== '0) begin failures++; $display("FAIL reset_sym_reg: got %b expected 0", sym_reg); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", drop); end
      reset_n = 1'b1;
      step(5);
   endtask

   task automatic test_basic_letter();
      int base;
      int v0;
      base = got_q.size();
      v0   = valid_cnt;
      press(6);
      step(5);
      checks++; if (sym_count !== 3'd1) begin failures++; $display("FAIL basic_count_after_dot: got %0d expected 1", sym_count); end
      checks++; if (sym_reg[0] !== 1'b0) begin failures++; $display("FAIL basic_dot_bit: got %b expected 0", sym_reg[0]); end
      press(16);
      step(5);
      checks++; if (sym_count !== 3'd2) begin failures++; $display("FAIL basic_count_after_dash: got %0d expected 2", sym_count); end
      checks++; if (sym_reg !== 5'b00010) begin failures++; $display("FAIL basic_sym_reg: got %b expected 00010", sym_reg); end
      step(40);
      checks++; if (got_q.size() - base != 1) begin failures++; $display("FAIL basic_letter_count: got %0d expected 1", got_q.size() - base); end
      else begin
         checks++; if (got_q[base] !== 6'b000110) begin failures++; $display("FAIL basic_code: got %b expected 000110", got_q[base]); end
      end
      checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cnt - v0); end
      checks++; if (sym_count !== 3'd0) begin failures++; $display("FAIL basic_count_after_close: got %0d expected 0", sym_count); end
   endtask

   task automatic test_overflow();
      int base;
      do_clear();
      base = got_q.size();
      for (int i = 0; i < 6; i++) begin
         press(6);
         step(5);
      end
      checks++; if (sym_count !== 3'd5) begin failures++; $display("FAIL ovf_sym_count: got %0d expected 5", sym_count); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      checks++; if (sym_reg !== 5'b00000) begin failures++; $display("FAIL ovf_sym_reg: got %b expected 00000", sym_reg); end
      step(40);
      checks++; if (got_q.size() - base != 1) begin failures++; $display("FAIL ovf_letter_count: got %0d expected 1", got_q.size() - base); end
      else begin
         checks++; if (got_q[base] !== 6'b100000) begin failures++; $display("FAIL ovf_code: got %b expected 100000", got_q[base]); end
      end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
      do_clear();
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
   endtask

   task automatic test_backpressure();
      int base;
      do_clear();
      out_ready = 1'b0;
      press(6);
      step(40);
      checks++; if (code_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid: got %b expected 1", code_valid); end
      checks++; if (code_out !== 6'b000010) begin failures++; $display("FAIL bp_first_code: got %b expected 000010", code_out); end
      checks++; if (drop !== 1'b0) begin failures++; $display("FAIL bp_no_drop_yet: got %b expected 0", drop); end
      press(16);
      step(40);
      checks++; if (code_out !== 6'b000010) begin failures++; $display("FAIL bp_code_held: got %b expected 000010", code_out); end
      checks++; if (code_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held: got %b expected 1", code_valid); end
      checks++; if (drop !== 1'b1) begin failures++; $display("FAIL bp_drop: got %b expected 1", drop); end
      base = got_q.size();
      out_ready = 1'b1;
      step(1);
      checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL bp_consume: got %b expected 0", code_valid); end
      checks++; if (got_q.size() - base != 1) begin failures++; $display("FAIL bp_accept_count: got %0d expected 1", got_q.size() - base); end
      step(3);
   endtask

   task automatic test_glitch();
      int v0;
      int maxc;
      do_clear();
      v0   = valid_cnt;
      maxc = 0;
      step(3);
      press(1);
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (int'(sym_count) > maxc) maxc = int'(sym_count);
      end
      checks++; if (maxc != 0) begin failures++; $display("FAIL glitch_sym_count: got %0d expected 0", maxc); end
      checks++; if (valid_cnt != v0) begin failures++; $display("FAIL glitch_no_code: got %0d valid cycles expected 0", valid_cnt - v0); end
   endtask

   task automatic test_reset_mid_press();
      int v0;
      int base;
      v0   = valid_cnt;
      base = got_q.size();
      key_in = 1'b1;
      step(10);
      reset_n = 1'b0;
      step(2);
      checks++; if (sym_count !== 3'd0) begin failures++; $display("FAIL rstpress_count_in_reset: got %0d expected 0", sym_count); end
      reset_n = 1'b1;
      step(6);
      key_in = 1'b0;
      step(50);
      checks++; if (sym_count !== 3'd0) begin failures++; $display("FAIL rstpress_sym_count: got %0d expected 0", sym_count); end
      checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL rstpress_code_valid: got %b expected 0", code_valid); end
      checks++; if (valid_cnt != v0 || got_q.size() != base) begin failures++; $display("FAIL rstpress_no_code: got %0d letters expected 0", got_q.size() - base); end
   endtask

   task automatic test_clear_held_key();
      int base;
      base = got_q.size();
      key_in = 1'b1;
      step(10);
      do_clear();
      step(10);
      key_in = 1'b0;
      step(40);
      checks++; if (sym_count !== 3'd0) begin failures++; $display("FAIL clrheld_sym_count: got %0d expected 0", sym_count); end
      checks++; if (got_q.size() != base) begin failures++; $display("FAIL clrheld_no_code: got %0d letters expected 0", got_q.size() - base); end
      press(6);
      step(40);
      checks++; if (got_q.size() - base != 1) begin failures++; $display("FAIL clrheld_next_letter: got %0d letters expected 1", got_q.size() - base); end
      else begin
         checks++; if (got_q[base] !== 6'b000010) begin failures++; $display("FAIL clrheld_next_code: got %b expected 000010", got_q[base]); end
      end
   endtask

   task automatic test_clear_in_gap();
      int base;
      do_clear();
      base = got_q.size();
      for (int i = 0; i < 3; i++) begin
         press(6);
         step(5);
      end
      checks++; if (sym_count !== 3'd3) begin failures++; $display("FAIL clrgap_count_before: got %0d expected 3", sym_count); end
      do_clear();
      checks++; if (sym_count !== 3'd0) begin failures++; $display("FAIL clrgap_count_after: got %0d expected 0", sym_count); end
      checks++; if (sym_reg !== '0) begin failures++; $display("FAIL clrgap_sym_reg: got %b expected 0", sym_reg); end
      step(40);
      checks++; if (got_q.size() != base) begin failures++; $display("FAIL clrgap_no_code: got %0d letters expected 0", got_q.size() - base); end
      checks++; if (code_valid !== 1'b0) begin failures++; $display("FAIL clrgap_valid: got %b expected 0", code_valid); end
   endtask

   task automatic test_random_letters();
      int base;
      int n;
      logic [7:0] syms;
      bit exp_ovf;
      do_clear();
      out_ready = 1'b1;
      base = got_q.size();
      exp_q.delete();
      exp_ovf = 1'b0;
      for (int l = 0; l < 12; l++) begin
         n    = int'($urandom_range(1, 7));
         syms = 8'($urandom);
         send_symbols(n, syms, 1'b1);
         step(40);
         exp_q.push_back(letter_code(n, syms));
         if (n > int'(MAX_SYMBOLS)) exp_ovf = 1'b1;
      end
      checks++;
      if (got_q.size() - base != exp_q.size()) begin
         failures++;
         $display("FAIL rand_letter_count: got %0d expected %0d", got_q.size() - base, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[base + i] !== exp_q[i]) begin
               failures++;
               $display("FAIL rand_code[%0d]: got %b expected %b", i, got_q[base + i], exp_q[i]);
            end
         end
      end
      checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL rand_overflow: got %b expected %b", overflow, exp_ovf); end
      checks++; if (drop !== 1'b0) begin failures++; $display("FAIL rand_drop: got %b expected 0", drop); end
   endtask

   initial begin
      test_reset();
      test_basic_letter();
      test_overflow();
      test_backpressure();
      test_glitch();
      test_reset_mid_press();
      test_clear_held_key();
      test_clear_in_gap();
      test_random_letters();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/morse_symbol_decoder.md
MORSE_SYMBOL_DECODER -- requirements
Module: morse_symbol_decoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1_250_000, meaning clk cycles per timing tick (minimum 2).
REQ-002 SHALL have parameter DOT_MAX_TICKS, default 2, meaning the longest press in ticks classified as a dot.
REQ-003 SHALL have parameter LETTER_GAP_TICKS, default 6, meaning key-up ticks that close a letter.
REQ-004 SHALL have parameter MAX_SYMBOLS, default 5, meaning symbols per letter (range 1..8).
REQ-005 SHALL expose clk  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL expose reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL expose key_in  input  1  raw Morse key, asynchronous to clk, high = pressed.
REQ-008 SHALL expose clear  input  1  synchronous clear of buffer, output and flags.
REQ-009 SHALL expose out_ready  input  1  consumer accepts code_out this cycle.
REQ-010 SHALL expose code_out  output  MAX_SYMBOLS+1  sentinel-encoded letter.
REQ-011 SHALL expose code_valid  output  1  code_out holds an unconsumed letter.
REQ-012 SHALL expose sym_count  output  clog2(MAX_SYMBOLS+1)  symbols buffered in the open letter.
REQ-013 SHALL expose sym_reg  output  MAX_SYMBOLS  buffered symbols; bit i = symbol i, 0 = dot, 1 = dash.
REQ-014 SHALL expose overflow  output  1  sticky; a symbol was dropped because the buffer was full.
REQ-015 SHALL expose drop  output  1  sticky; a completed letter was discarded under backpressure.

Function
REQ-016 SHALL pass key_in through a 2-flop synchronizer; all decisions use the synchronized key.
REQ-017 SHALL produce a one-cycle tick every TICK_DIV clk cycles from a free-running prescaler.
REQ-018 SHALL implement FSM states IDLE (key up, sym_count=0), PRESS (key down), GAP (key up, sym_count>0).
REQ-019 SHALL go IDLE->PRESS and GAP->PRESS on key press; press counter and gap counter clear on entry.
REQ-020 SHALL increment the press counter on each tick in PRESS, saturating at DOT_MAX_TICKS+1.
REQ-021 SHALL, on release with press count 0, discard the press and return to the prior state (IDLE or GAP).
REQ-022 SHALL, on release with press count 1..DOT_MAX_TICKS, append a dot; above DOT_MAX_TICKS, append a dash; then enter GAP.
REQ-023 SHALL write the appended symbol to sym_reg[sym_count] and increment sym_count in the release cycle.
REQ-024 SHALL, when sym_count=MAX_SYMBOLS at release, drop the symbol, leave buffer unchanged and set overflow.
REQ-025 SHALL increment the gap counter on each tick in GAP; on reaching LETTER_GAP_TICKS it completes the letter.
REQ-026 SHALL form the completed code as sym_reg bits [sym_count-1:0], a 1 at bit sym_count, zeros above.
REQ-027 SHALL, in the completion cycle, clear sym_reg and sym_count and enter IDLE.
REQ-028 SHALL load code_out and set code_valid on the next edge after completion if code_valid=0 or out_ready=1.
REQ-029 SHALL, if code_valid=1 and out_ready=0 at completion, discard the new code, keep code_out, and set drop.
REQ-030 SHALL clear code_valid when code_valid and out_ready are both 1 and no new code loads.
REQ-031 SHALL keep code_out stable while code_valid=1 and out_ready=0.
REQ-032 SHALL give clear priority over all events: IDLE, buffer empty, code_valid=0, overflow=0, drop=0, counters 0.
REQ-033 SHALL, when clear is asserted with the key held, stay in IDLE until the next rising edge of the synchronized key.

Reset
REQ-034 SHALL, while reset_n=0, force state IDLE, code_out=0, code_valid=0, sym_count=0, sym_reg=0, overflow=0, drop=0, and all counters, prescaler and synchronizer to 0.
REQ-035 SHALL abandon a press or letter in progress at reset, with no code emitted after release.

Structure
REQ-036 SHALL place the FSM state encoding and the code-width function (MAX_SYMBOLS+1) in shared package morse_pkg.
REQ-037 SHALL instantiate one sub-module, morse_tick_gen, containing the prescaler and tick output.

Verification (TICK_DIV=4, DOT_MAX_TICKS=2, LETTER_GAP_TICKS=6, MAX_SYMBOLS=5)
REQ-038 SHALL cover: 2-tick press, 4-tick press, idle, out_ready=1 -> code_out=6'b000110, code_valid for one cycle.
REQ-039 SHALL cover: six 1-tick presses, then gap -> code_out=6'b100000, overflow=1.
REQ-040 SHALL cover: out_ready=0, letters "." then "-" -> code_out stays 6'b000010, drop=1.
REQ-041 SHALL cover: a 1-cycle key pulse in IDLE -> sym_count stays 0, no code emitted.
REQ-042 SHALL cover: reset_n low mid-PRESS, then release -> sym_count=0, code_valid=0.
REQ-043 SHALL cover: clear in GAP with sym_count=3 -> sym_count=0, IDLE, no code emitted.
